// File: rtl/inst_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inst_loader: frames a byte stream into instruction-RAM word writes,  |
// | verifies an XOR checksum and holds the CPU until the image is valid. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module inst_loader #(
  parameter int A = 10,
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         wr_en,
  output logic [A-1:0] wr_addr,
  output logic [W-1:0] wr_data,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic         cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CHK, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] C_WORDS = 17'(2**A);

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_in_ready, r_wr_en, r_busy, r_done, r_error, r_cpu_hold;
  logic [A-1:0]   r_wr_addr;
  logic [W-1:0]   r_wr_data;
  logic [7:0]     r_len_lo;
  logic [15:0]    r_len;
  logic [7:0]     r_lo;
  logic [7:0]     r_acc;
  logic [A-1:0]   r_idx;
  logic           w_xfer;
  logic           w_idle_like;
  logic           w_reading;
  logic [15:0]    w_len_full;
  logic [A:0]     w_idx_inc;
  logic           w_last;

  assign w_xfer      = in_valid && r_in_ready;
  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
  assign w_len_full  = {in_data, r_len_lo};
  // One extra bit so that a full 2**A-word image terminates correctly.
  assign w_idx_inc   = {1'b0, r_idx} + (A+1)'(1);
  assign w_last      = (16'(w_idx_inc) == r_len);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (start) w_state_nxt = S_LEN_LO;
      S_LEN_LO:  if (w_xfer) w_state_nxt = S_LEN_HI;
      S_LEN_HI: begin
        if (w_xfer) begin
          if ({1'b0, w_len_full} > C_WORDS) w_state_nxt = S_ERR;
          else if (w_len_full == 16'd0)     w_state_nxt = S_CHK;
          else                              w_state_nxt = S_DATA_LO;
        end
      end
      S_DATA_LO: if (w_xfer) w_state_nxt = S_DATA_HI;
      S_DATA_HI: if (w_xfer) w_state_nxt = w_last ? S_CHK : S_DATA_LO;
      S_CHK:     if (w_xfer) w_state_nxt = (in_data == r_acc) ? S_DONE : S_ERR;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  assign w_reading = (w_state_nxt == S_LEN_LO) || (w_state_nxt == S_LEN_HI) ||
                     (w_state_nxt == S_DATA_LO) || (w_state_nxt == S_DATA_HI) ||
                     (w_state_nxt == S_CHK);

  // Status outputs are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_cpu_hold <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= w_reading;
      r_busy     <= w_reading;
      r_done     <= (w_state_nxt == S_DONE);
      r_error    <= (w_state_nxt == S_ERR);
      r_cpu_hold <= (w_state_nxt != S_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_len_lo  <= 8'd0;
      r_len     <= 16'd0;
      r_lo      <= 8'd0;
      r_acc     <= 8'd0;
      r_idx     <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_idle_like && start) r_acc <= 8'd0;
      if (w_xfer) begin
        if (r_state != S_CHK) r_acc <= r_acc ^ in_data;
        case (r_state)
          S_LEN_LO:  r_len_lo <= in_data;
          S_LEN_HI: begin
            r_len <= w_len_full;
            r_idx <= '0;
          end
          S_DATA_LO: r_lo <= in_data;
          S_DATA_HI: begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_idx;
            r_wr_data <= {in_data[W-9:0], r_lo};
            r_idx     <= w_idx_inc[A-1:0];
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready = r_in_ready;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign cpu_hold = r_cpu_hold;

endmodule
`default_nettype wire

// File: tb/tb_inst_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_inst_loader: scoreboard bench for inst_loader with a frame-level  |
// | reference model. Rev 1.0                                             |
// +----------------------------------------------------------------------+
module tb_inst_loader;

  localparam int A = 10;
  localparam int W = 9;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   in_data = 8'd0;
  logic         in_valid = 1'b0;
  logic         in_ready, wr_en, busy, done, error, cpu_hold;
  logic [A-1:0] wr_addr;
  logic [W-1:0] wr_data;

  inst_loader #(.A(A), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .error(error), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  int          nchk = 0;
  int          nerr = 0;
  int          wr_count = 0;
  int          exp_addr[$];
  int          exp_data[$];
  logic [7:0]  frame[$];
  int          frame_n;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest predicted write.
  always @(negedge clk) begin
    if (wr_en) begin
      wr_count++;
      if (exp_addr.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none", wr_addr, wr_data);
      end else begin
        chk("wr_addr", int'(wr_addr), exp_addr.pop_front());
        chk("wr_data", int'(wr_data), exp_data.pop_front());
      end
    end
  end

  // Reference model: parse the frame by its format rules; 0=done, 1=bad length, 2=bad checksum.
  function automatic int model_frame();
    int n;
    int x;
    int lo;
    int hi;
    n = int'(frame[0]) + 256 * int'(frame[1]);
    frame_n = n;
    if (n > (1 << A)) return 1;
    x = int'(frame[0]) ^ int'(frame[1]);
    for (int i = 0; i < n; i++) begin
      lo = int'(frame[2 + 2*i]);
      hi = int'(frame[3 + 2*i]);
      exp_addr.push_back(i);
      exp_data.push_back((hi * 256 + lo) % (1 << W));
      x = x ^ lo ^ hi;
    end
    return (int'(frame[2 + 2*n]) == x) ? 0 : 2;
  endfunction

  task automatic build_frame(input int n, input bit bad);
    logic [7:0] b;
    logic [7:0] x;
    frame.delete();
    frame.push_back(8'(n));
    frame.push_back(8'(n >> 8));
    x = frame[0] ^ frame[1];
    if (n <= (1 << A)) begin
      for (int i = 0; i < 2*n; i++) begin
        b = 8'($urandom);
        frame.push_back(b);
        x = x ^ b;
      end
      frame.push_back(bad ? (x ^ (8'h01 << $urandom_range(0, 7))) : x);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_byte(input logic [7:0] b);
    int cnt;
    cnt = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 50) chk("in_ready_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // gap < 0 selects a random 0..2 cycle gap after every byte.
  task automatic run_frame(input int gap, input bit do_start);
    int outcome;
    int nbytes;
    int g;
    int wr0;
    int nexp;
    outcome = model_frame();
    nexp    = exp_addr.size();
    wr0     = wr_count;
    if (do_start) pulse_start();
    chk("busy_after_start", busy, 1);
    chk("error_cleared", error, 0);
    chk("done_cleared", done, 0);
    nbytes = (outcome == 1) ? 2 : frame.size();
    for (int i = 0; i < nbytes; i++) begin
      send_byte(frame[i]);
      if (i >= 3 && i < 2 + 2*frame_n && ((i - 2) % 2) == 1)
        chk("write_latency", wr_en, 1);
      if (i < nbytes - 1) begin
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        repeat (g) begin
          @(negedge clk);
          chk("in_ready_stall", in_ready, 1);
        end
      end
    end
    chk("done", done, outcome == 0);
    chk("error", error, outcome != 0);
    chk("cpu_hold", cpu_hold, outcome != 0);
    chk("busy_end", busy, 0);
    chk("in_ready_end", in_ready, 0);
    @(negedge clk);
    chk("sb_drained", exp_addr.size(), 0);
    chk("write_count", wr_count - wr0, nexp);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, int'(wr_addr), 0);
    chk({tag, "_wr_data"}, int'(wr_data), 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_cpu_hold"}, cpu_hold, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal stream, back to back.
    frame = {8'h02, 8'h00, 8'hAB, 8'h01, 8'hFF, 8'h00, 8'h57};
    run_frame(0, 1'b1);

    // Same stream with 3-cycle stalls between bytes.
    run_frame(3, 1'b1);

    // Bad checksum, then a new Start clears Error.
    frame = {8'h02, 8'h00, 8'hAB, 8'h01, 8'hFF, 8'h00, 8'h56};
    run_frame(0, 1'b1);
    pulse_start();
    chk("restart_error", error, 0);
    chk("restart_busy", busy, 1);

    // Illegal length 1025 on the frame already started.
    frame = {8'h01, 8'h04};
    run_frame(0, 1'b0);

    // Zero length with a Start pulse during Busy.
    frame = {8'h00, 8'h00, 8'h00};
    void'(model_frame());
    pulse_start();
    send_byte(frame[0]);
    pulse_start();
    chk("start_ignored_busy", busy, 1);
    chk("start_ignored_ready", in_ready, 1);
    send_byte(frame[1]);
    send_byte(frame[2]);
    chk("zero_len_done", done, 1);
    chk("zero_len_error", error, 0);
    chk("zero_len_writes", exp_addr.size(), 0);

    // Randomized frames including occasional checksum faults and bad lengths.
    for (int k = 0; k < 10; k++) begin
      build_frame(int'($urandom_range(1, 12)), ($urandom_range(0, 3) == 0));
      run_frame(-1, 1'b1);
    end
    build_frame(1025 + int'($urandom_range(0, 3000)), 1'b0);
    run_frame(-1, 1'b1);

    // Largest legal image.
    build_frame(1 << A, 1'b0);
    run_frame(0, 1'b1);

    // Reset after the first word of a two-word load.
    frame = {8'h02, 8'h00, 8'hAB, 8'h01, 8'hFF, 8'h00, 8'h57};
    void'(model_frame());
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(frame[i]);
    chk("first_write_seen", wr_en, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_values("async_reset");
    exp_addr.delete();
    exp_data.delete();
    in_valid = 1'b1;
    in_data  = 8'hFF;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_values("after_reset");
    run_frame(0, 1'b1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
